// File: rtl/connect4_pkg.sv
// ============================================================================
// connect4_pkg: shared Connect-4 board dimensions, cell colours, FSM states.
// Rev 1.0
// ============================================================================
`default_nettype none

package connect4_pkg;

    localparam int COLS     = 7;
    localparam int ROWS     = 6;
    localparam int COL_W    = 3;
    localparam int ROW_W    = 3;
    localparam int CELLS    = COLS * ROWS;
    localparam int CNT_W    = $clog2(CELLS + 1);
    localparam int COL_SPAN = 1 << COL_W;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b01;
    localparam logic [1:0] CELL_P2    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_TOGGLE   = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/col_height_bank.sv
// ============================================================================
// col_height_bank: per-column saturating fill heights with indexed read/increment.
// Rev 1.0
// ============================================================================
`default_nettype none

module col_height_bank
    import connect4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [COL_W-1:0] rd_col_i,
    input  logic             inc_i,
    input  logic [COL_W-1:0] inc_col_i,
    output logic [ROW_W-1:0] height_o,
    output logic [COLS-1:0]  col_full_o
);

    logic [ROW_W-1:0] height_q [COLS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < COLS; c++) begin
                height_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < COLS; c++) begin
                if (inc_i && (inc_col_i == COL_W'(c)) && (height_q[c] != ROW_W'(ROWS))) begin
                    height_q[c] <= height_q[c] + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_full
        assign col_full_o[c] = (height_q[c] == ROW_W'(ROWS));
    end

    always_comb begin
        height_o = '0;
        if (rd_col_i < COL_W'(COLS)) begin
            height_o = height_q[rd_col_i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/move_controller.sv
// ============================================================================
// move_controller: turns a drop request into one validated board write followed
// by a single-cycle turn toggle pulse. Rev 1.0
// ============================================================================
`default_nettype none

module move_controller
    import connect4_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             turn,
    input  logic             drop,
    input  logic [COL_W-1:0] col_sel,
    input  logic             game_over,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [1:0]       wr_color,
    output logic             turn_toggle,
    output logic             move_reject,
    output logic             board_full,
    output logic             busy
);

    state_t             state_q;
    logic               drop_q;
    logic [COL_W-1:0]   col_q;
    logic               turn_q;
    logic [CNT_W-1:0]   count_q;

    logic [ROW_W-1:0]    w_height;
    logic [COLS-1:0]     w_col_full;
    logic [COL_SPAN-1:0] w_full_ext;
    logic                w_reject;

    col_height_bank u_heights (
        .clk        (clk),
        .reset      (reset),
        .rd_col_i   (col_q),
        .inc_i      (state_q == ST_WRITE),
        .inc_col_i  (col_q),
        .height_o   (w_height),
        .col_full_o (w_col_full)
    );

    // Heights and count cannot change between IDLE and CHECK, so the reject
    // decision is taken at the edge and the flag itself is the CHECK-cycle pulse.
    assign w_full_ext = COL_SPAN'(w_col_full);
    assign w_reject   = (col_sel >= COL_W'(COLS)) || w_full_ext[col_sel] || board_full;

    assign board_full = (count_q == CNT_W'(CELLS));
    assign busy       = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            drop_q      <= 1'b0;
            col_q       <= '0;
            turn_q      <= 1'b0;
            count_q     <= '0;
            wr_en       <= 1'b0;
            wr_row      <= '0;
            wr_col      <= '0;
            wr_color    <= CELL_EMPTY;
            turn_toggle <= 1'b0;
            move_reject <= 1'b0;
        end else begin
            drop_q <= drop;
            case (state_q)
                ST_IDLE: begin
                    if (drop && !drop_q && !game_over) begin
                        col_q       <= col_sel;
                        turn_q      <= turn;
                        move_reject <= w_reject;
                        state_q     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    move_reject <= 1'b0;
                    if (move_reject) begin
                        state_q <= ST_WAIT_REL;
                    end else begin
                        wr_en    <= 1'b1;
                        wr_row   <= w_height;
                        wr_col   <= col_q;
                        wr_color <= turn_q ? CELL_P2 : CELL_P1;
                        state_q  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wr_en       <= 1'b0;
                    turn_toggle <= 1'b1;
                    count_q     <= count_q + 1'b1;
                    state_q     <= ST_TOGGLE;
                end
                ST_TOGGLE: begin
                    turn_toggle <= 1'b0;
                    state_q     <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!drop) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
